// File: rtl/mac_pad_serdes.sv
// Narrow-pad front end for the MAC core: assembles operands from PAD_W-bit beats, starts the
// core, and streams the result back out. Define MAC_PAD_SERDES_PARITY_EN for odd parity on din.
module mac_pad_serdes #(
  parameter int PAD_W = 8,
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAD_W-1:0] din,
  input  logic             din_valid,
  input  logic             din_sof,
  input  logic             din_par,
  output logic             busy,
  output logic [PAD_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             err,
  output logic [A_W-1:0]   a_o,
  output logic [B_W-1:0]   b_o,
  output logic [ACC_W-1:0] acc_in_o,
  output logic             core_start,
  input  logic             core_done,
  input  logic [ACC_W-1:0] core_result
);

  localparam int SH_W      = A_W + B_W + ACC_W;
  localparam int IN_BEATS  = SH_W / PAD_W;
  localparam int OUT_BEATS = ACC_W / PAD_W;
  localparam int IN_CNT_W  = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int OUT_CNT_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

  if ((A_W % PAD_W) != 0 || (B_W % PAD_W) != 0 || (ACC_W % PAD_W) != 0) begin : g_width_check
    $error("mac_pad_serdes: A_W, B_W and ACC_W must be multiples of PAD_W");
  end

  typedef enum logic [1:0] {
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_UNLOAD
  } state_e;

  state_e               state_q, state_d;
  logic [IN_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [SH_W-1:0]      shadow_q, shadow_d;
  logic [A_W-1:0]       a_q, a_d;
  logic [B_W-1:0]       b_q, b_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     shift_q, shift_d;
  logic [IN_CNT_W-1:0]  slot;
  logic                 par_ok;

`ifdef MAC_PAD_SERDES_PARITY_EN
  logic err_q;

  assign par_ok = ^{din, din_par};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == S_LOAD && din_valid && !par_ok) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_par;

  assign unused_par = din_par;
  assign par_ok     = 1'b1;
  assign err        = 1'b0;
`endif

  // A start-of-frame beat always lands in slot 0, whatever the running count.
  assign slot = din_sof ? '0 : beat_cnt_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    out_cnt_d  = out_cnt_q;
    shadow_d   = shadow_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    shift_d    = shift_q;

    unique case (state_q)
      S_LOAD: begin
        if (din_valid) begin
          if (!par_ok) begin
            beat_cnt_d = '0;
          end else begin
            shadow_d[slot*PAD_W +: PAD_W] = din;
            if (slot == IN_CNT_W'(IN_BEATS - 1)) begin
              // Operands are loaded on the way into ISSUE so they are stable alongside core_start.
              beat_cnt_d = '0;
              a_d        = shadow_d[0 +: A_W];
              b_d        = shadow_d[A_W +: B_W];
              acc_d      = shadow_d[A_W+B_W +: ACC_W];
              state_d    = S_ISSUE;
            end else begin
              beat_cnt_d = slot + IN_CNT_W'(1);
            end
          end
        end
      end

      S_ISSUE, S_WAIT: begin
        if (core_done) begin
          shift_d = core_result;
          state_d = S_UNLOAD;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_UNLOAD: begin
        if (dout_ready) begin
          shift_d = shift_q >> PAD_W;
          if (out_cnt_q == OUT_CNT_W'(OUT_BEATS - 1)) begin
            out_cnt_d = '0;
            state_d   = S_LOAD;
          end else begin
            out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
          end
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD;
      beat_cnt_q <= '0;
      out_cnt_q  <= '0;
      shadow_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      shift_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      out_cnt_q  <= out_cnt_d;
      shadow_q   <= shadow_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      shift_q    <= shift_d;
    end
  end

  assign busy       = (state_q != S_LOAD);
  assign core_start = (state_q == S_ISSUE);
  assign dout_valid = (state_q == S_UNLOAD);
  assign dout       = (state_q == S_UNLOAD) ? shift_q[PAD_W-1:0] : '0;
  assign a_o        = a_q;
  assign b_o        = b_q;
  assign acc_in_o   = acc_q;

endmodule

// File: tb/tb_mac_pad_serdes.sv
// Directed/randomised bench for mac_pad_serdes: frames are built from whole operands and the
// expected pad beats are sliced out of those operands; the core is modelled by the bench.
module tb_mac_pad_serdes;

  localparam int PAD_W     = 8;
  localparam int A_W       = 16;
  localparam int B_W       = 16;
  localparam int ACC_W     = 32;
  localparam int IN_BEATS  = (A_W + B_W + ACC_W) / PAD_W;
  localparam int OUT_BEATS = ACC_W / PAD_W;

  typedef struct {
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic [ACC_W-1:0] acc;
  } frame_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [PAD_W-1:0] din;
  logic             din_valid;
  logic             din_sof;
  logic             din_par;
  logic             busy;
  logic [PAD_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             err;
  logic [A_W-1:0]   a_o;
  logic [B_W-1:0]   b_o;
  logic [ACC_W-1:0] acc_in_o;
  logic             core_start;
  logic             core_done;
  logic [ACC_W-1:0] core_result;

  int n_cmp      = 0;
  int n_bad      = 0;
  int starts     = 0;
  int exp_starts = 0;

  always #5 clk = ~clk;

  mac_pad_serdes #(.PAD_W(PAD_W), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .din_par(din_par), .busy(busy), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .err(err), .a_o(a_o), .b_o(b_o), .acc_in_o(acc_in_o),
    .core_start(core_start), .core_done(core_done), .core_result(core_result)
  );

  always @(posedge clk) if (core_start) starts <= starts + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PAD_W-1:0] in_beat(frame_t f, int i);
    logic [A_W+B_W+ACC_W-1:0] cat;
    cat = {f.acc, f.b, f.a};
    return PAD_W'(cat >> (PAD_W * i));
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f.a   = A_W'($urandom);
    f.b   = B_W'($urandom);
    f.acc = ACC_W'($urandom);
    return f;
  endfunction

  task automatic send_beat(input logic [PAD_W-1:0] d, input logic sof, input logic bad);
    din       = d;
    din_valid = 1'b1;
    din_sof   = sof;
    core_done = 1'b0;
`ifdef MAC_PAD_SERDES_PARITY_EN
    din_par   = ~(^d) ^ bad;
`else
    din_par   = bad ^ logic'($urandom_range(0, 1));
`endif
    @(negedge clk);
    din_valid = 1'b0;
    din_sof   = 1'b0;
  endtask

  // Optional garbage prefix forces a resync via din_sof on the real first beat.
  task automatic send_frame(input frame_t f, input int garbage, input int max_gap);
    int gap;
    for (int i = 0; i < garbage; i++) send_beat(PAD_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < IN_BEATS; i++) begin
      if (i > 0 && max_gap > 0) begin
        gap = $urandom_range(0, max_gap);
        repeat (gap) begin
          din         = PAD_W'($urandom);
          din_sof     = logic'($urandom_range(0, 1));
          core_done   = logic'($urandom_range(0, 1));
          core_result = ACC_W'($urandom);
          @(negedge clk);
        end
        din_sof   = 1'b0;
        core_done = 1'b0;
      end
      send_beat(in_beat(f, i), (i == 0) && (garbage > 0), 1'b0);
    end
    exp_starts++;
  endtask

  task automatic do_core(input logic [ACC_W-1:0] r, input int lat, input bit noise);
    if (lat > 0) begin
      @(negedge clk);
      check("wait_busy", busy, 1);
      check("wait_no_start", core_start, 0);
      repeat (lat - 1) begin
        din_valid = noise;
        din       = PAD_W'($urandom);
        din_sof   = logic'($urandom_range(0, 1));
        @(negedge clk);
      end
      din_valid = 1'b0;
      din_sof   = 1'b0;
    end
    core_result = r;
    core_done   = 1'b1;
    @(negedge clk);
    core_done   = 1'b0;
    core_result = ACC_W'($urandom);
  endtask

  task automatic unload(input logic [ACC_W-1:0] r, input logic [31:0] pat, input int plen,
                        input bit noise);
    int k   = 0;
    int cyc = 0;
    while (k < OUT_BEATS && cyc < 64) begin
      if (plen > 0) dout_ready = (cyc < plen) ? pat[cyc] : 1'b1;
      else          dout_ready = ($urandom_range(0, 2) != 0);
      din_valid = noise && ($urandom_range(0, 1) != 0);
      din_sof   = logic'($urandom_range(0, 1));
      din       = PAD_W'($urandom);
      check("unload_valid", dout_valid, 1);
      check($sformatf("dout_beat%0d", k), dout, PAD_W'(r >> (PAD_W * k)));
      if (dout_ready) k++;
      @(negedge clk);
      cyc++;
    end
    din_valid  = 1'b0;
    din_sof    = 1'b0;
    dout_ready = 1'b0;
    check("unload_beats", k, OUT_BEATS);
    check("valid_drop", dout_valid, 0);
    check("dout_zero", dout, 0);
    check("busy_drop", busy, 0);
  endtask

  task automatic run_frame(input frame_t f, input int garbage, input int max_gap,
                           input logic [ACC_W-1:0] r, input int lat, input bit noise,
                           input logic [31:0] pat, input int plen);
    send_frame(f, garbage, max_gap);
    check("issue_start", core_start, 1);
    check("issue_busy", busy, 1);
    do_core(r, lat, noise);
    check("a_o", a_o, f.a);
    check("b_o", b_o, f.b);
    check("acc_in_o", acc_in_o, f.acc);
    check("start_count", starts, exp_starts);
    unload(r, pat, plen, noise);
  endtask

  initial begin
    frame_t f;
    logic [ACC_W-1:0] r;

    rst = 1'b1; din = '0; din_valid = 1'b0; din_sof = 1'b0; din_par = 1'b0;
    dout_ready = 1'b0; core_done = 1'b0; core_result = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_err", err, 0);
    check("rst_a_o", a_o, 0);
    check("rst_b_o", b_o, 0);
    check("rst_acc_in_o", acc_in_o, 0);
    rst = 1'b0;

    // Basic frame with the documented backpressure pattern 1,0,0,1,1,1.
    f.a = 16'h1234; f.b = 16'h00FF; f.acc = 32'hDEADBEEF;
    run_frame(f, 0, 0, 32'hCAFEF00D, 2, 1'b0, 32'b111001, 6);

    // Resync: three stray beats, then a start-of-frame beat.
    run_frame(rand_frame(), 3, 0, ACC_W'($urandom), 1, 1'b0, '0, 0);

    // Busy discard, then a frame with no din_sof must still start at slot 0.
    run_frame(rand_frame(), 0, 0, ACC_W'($urandom), 3, 1'b1, '0, 0);
    run_frame(rand_frame(), 0, 0, ACC_W'($urandom), 0, 1'b0, '0, 0);

    // Reset mid-unload after two accepted beats.
    f = rand_frame();
    r = ACC_W'($urandom);
    send_frame(f, 0, 0);
    do_core(r, 1, 1'b0);
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_dout_beat2", dout, PAD_W'(r >> (2 * PAD_W)));
    dout_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_dout", dout, 0);
    check("arst_dout_valid", dout_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_a_o", a_o, 0);
    check("arst_b_o", b_o, 0);
    check("arst_acc_in_o", acc_in_o, 0);
    @(negedge clk);
    rst = 1'b0;
    f.a = 16'h1234; f.b = 16'h00FF; f.acc = 32'hDEADBEEF;
    run_frame(f, 0, 0, 32'hCAFEF00D, 2, 1'b0, 32'b111001, 6);

    // Randomised frames: gaps with stray core_done, resync prefixes, latency 0..3, noise.
    for (int n = 0; n < 8; n++) begin
      run_frame(rand_frame(), $urandom_range(0, 5), 2, ACC_W'($urandom),
                $urandom_range(0, 3), 1'b1, '0, 0);
    end

`ifdef MAC_PAD_SERDES_PARITY_EN
    f = rand_frame();
    for (int i = 0; i < IN_BEATS; i++) send_beat(in_beat(f, i), 1'b0, i == 4);
    check("par_err", err, 1);
    check("par_no_issue", busy, 0);
    check("par_start_count", starts, exp_starts);
    f = rand_frame();
    r = ACC_W'($urandom);
    for (int i = 0; i < IN_BEATS; i++) send_beat(in_beat(f, i), i == 0, 1'b0);
    exp_starts++;
    check("par_resend_start", core_start, 1);
    do_core(r, 1, 1'b0);
    check("par_a_o", a_o, f.a);
    check("par_acc_in_o", acc_in_o, f.acc);
    unload(r, '0, 0, 1'b0);
    check("par_err_sticky", err, 1);
`else
    check("err_const", err, 0);
`endif

    check("final_start_count", starts, exp_starts);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_pad_serdes.md
Name: mac_pad_serdes

Overview:
- Pin-reduced successor to the MAC pad interface. Operands arrive over a narrow PAD_W-bit input bus and are assembled into full-width core operands.
- Once the operands are assembled, the block starts the MAC core, then shifts the ACC_W-bit result back out over a narrow PAD_W-bit output bus with a ready/valid handshake.
- Sits between the pad ring and the MAC core. Replaces 97 digital I/O pads with roughly 2*PAD_W+6.

Parameters:
- PAD_W, 8, width of the pad-side input and output data buses.
- A_W, 16, width of operand a.
- B_W, 16, width of operand b.
- ACC_W, 32, width of acc_in and of the result.
- Derived constants:
  - IN_BEATS = (A_W+B_W+ACC_W)/PAD_W, default 8.
  - OUT_BEATS = ACC_W/PAD_W, default 4.
- A_W, B_W and ACC_W must each be multiples of PAD_W. Elaboration fails otherwise.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din  in  PAD_W  pad-side input beat.
- din_valid  in  1  din carries a beat this cycle.
- din_sof  in  1  start of frame, qualified by din_valid.
- din_par  in  1  odd-parity bit for din (used only with PARITY_EN).
- busy  out  1  high when the block is not in LOAD; input beats are ignored while high.
- dout  out  PAD_W  pad-side output beat.
- dout_valid  out  1  dout holds a valid beat.
- dout_ready  in  1  pad-side acceptance of the current beat.
- err  out  1  sticky parity error flag.
- a_o  out  A_W  operand a to the core.
- b_o  out  B_W  operand b to the core.
- acc_in_o  out  ACC_W  accumulator input to the core.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  core result valid, single-cycle pulse.
- core_result  in  ACC_W  core result, sampled when core_done is high.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to LOAD and all counters clear.
  - All outputs go to 0: a_o, b_o, acc_in_o, dout, dout_valid, core_start, busy and err.
  - Any frame in progress is discarded.
- Beat order, input: little-endian across the concatenation {acc_in, b, a}.
  - Beat 0 is a[PAD_W-1:0].
  - Beat IN_BEATS-1 is acc_in[ACC_W-1:ACC_W-PAD_W].
- Beat order, output: LSB beat first.
- LOAD state:
  - Each cycle with din_valid=1 writes din into slot beat_cnt of the shadow register, then increments beat_cnt.
  - If din_sof=1 with din_valid=1, the beat is written to slot 0 and beat_cnt becomes 1, regardless of the prior count. This is the mid-frame resynchronisation rule.
  - The first beat after reset is accepted as slot 0 even without din_sof.
  - When slot IN_BEATS-1 is written, the next state is ISSUE.
- ISSUE state (1 cycle):
  - Shadow register is copied to a_o, b_o and acc_in_o.
  - core_start=1 for exactly this cycle; busy=1.
  - Next state is WAIT.
  - a_o, b_o and acc_in_o then hold their values until the next ISSUE.
- WAIT state:
  - On core_done=1, core_result is captured into the output shift register and the state moves to UNLOAD.
  - A core_done arriving in the same cycle as core_start is accepted.
  - There is no timeout.
- UNLOAD state:
  - dout = current low beat of the shift register; dout_valid=1.
  - On dout_valid && dout_ready, the register shifts right by PAD_W and out_cnt increments.
  - dout and dout_valid hold while dout_ready=0.
  - After beat OUT_BEATS-1 is accepted: dout_valid=0 on the next cycle, dout=0, and the state returns to LOAD with beat_cnt=0.
- Input handling while busy:
  - busy=1 in ISSUE, WAIT and UNLOAD.
  - din_valid in these states is ignored, including din_sof; it causes no error and no state change.
- Throughput:
  - Minimum frame time is IN_BEATS + 1 + core latency + OUT_BEATS cycles.
  - There is no input/output overlap.
- core_done outside WAIT is ignored.

Optional Feature:
- Macro: MAC_PAD_SERDES_PARITY_EN.
- When defined:
  - Each accepted beat must satisfy ^{din,din_par}=1 (odd parity).
  - On a mismatch in LOAD: the beat is not written, beat_cnt clears to 0 (the whole frame is dropped), and err is set.
  - err stays set until rst.
  - A beat that has both din_sof=1 and bad parity clears beat_cnt to 0.
- When undefined:
  - din_par is ignored.
  - err is constant 0, with no parity logic synthesised.

Test Plan:
- Basic frame:
  - Stimulus: reset, then 8 beats, all with din_valid=1, carrying a=0x1234, b=0x00FF, acc_in=0xDEADBEEF. The beats are 34,12,FF,00,EF,BE,AD,DE.
  - Required: core_start pulses once the cycle after beat 7. a_o=0x1234, b_o=0x00FF, acc_in_o=0xDEADBEEF.
- Output backpressure:
  - Stimulus: core_done with core_result=0xCAFEF00D; dout_ready toggles 1,0,0,1,1,1.
  - Required: dout sequence is 0D, F0, FE, CA, with each beat held while ready=0. dout_valid drops after CA and busy drops in the same cycle.
- Resync:
  - Stimulus: 3 beats, then a din_sof beat, then 7 more beats.
  - Required: operands are taken from the last 8 beats only; exactly one core_start.
- Busy discard:
  - Stimulus: din_valid pulses during WAIT and UNLOAD.
  - Required: no effect on outputs. The next frame assembles correctly from slot 0.
- Reset mid-op:
  - Stimulus: assert rst during UNLOAD after 2 beats.
  - Required: all outputs 0 immediately, without waiting for a clock edge. A subsequent full frame behaves as in the basic-frame case.
- Parity (PARITY_EN):
  - Stimulus: beat 4 sent with even parity.
  - Required: err=1, no core_start. A re-sent clean 8-beat frame issues normally and err stays 1.
